// File: rtl/netdma_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : netdma_irq_pkg
// Purpose  : Shared types for the interrupt coalescer.
//            Provides the coalescer FSM state enumeration.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package netdma_irq_pkg;

  localparam int STATE_W = 2;

  // IDLE : no batch open, live counter is zero
  // WAIT : batch open, counting events and cycles
  // IRQ  : interrupt raised, waiting for acknowledge
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_IRQ  = 2'd2
  } irq_state_e;

endpackage : netdma_irq_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear and load-one.
//            Priority: clear > load-one > increment. Never wraps.
// Ports    : clk_i    - clock, rising edge
//            rst_n_i  - asynchronous active-low reset (count -> 0)
//            clr_i    - synchronous clear to 0
//            load1_i  - synchronous load of the value 1
//            inc_i    - increment by one, holding at all-ones
//            cnt_o    - current count
//            sat_o    - count is at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load1_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat_o = (cnt_q == MAX_VAL);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = W'(1);
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : irq_coalescer
// Purpose  : Interrupt coalescer. Collects single-cycle event pulses into
//            batches and raises a level interrupt when either the event
//            threshold is met or the batch timeout expires. Events arriving
//            while the interrupt is pending are carried into the next batch.
// Ports    : clk_i        - clock, rising edge
//            rst_n_i      - asynchronous active-low reset
//            enable_i     - coalescer enable; low clears everything next edge
//            event_i      - one event per high cycle
//            thresh_i     - events per interrupt (0 behaves as 1), used live
//            timeout_i    - cycles from first batch event to forced IRQ,
//                           0 disables the timer, used live
//            ack_i        - interrupt acknowledge (ignored unless in IRQ)
//            irq_o        - registered level interrupt request
//            batch_cnt_o  - event count of the batch that raised irq_o
//            sat_o        - sticky: live counter saturated since last ack
// Revision : 1.0 - initial release
// ============================================================================
module irq_coalescer
  import netdma_irq_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TMR_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             event_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic [TMR_W-1:0] timeout_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic [CNT_W-1:0] batch_cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  irq_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] batch_q, batch_d;
  logic             sat_q, sat_d;

  logic             cnt_clr, cnt_ld1, cnt_inc;
  logic             tmr_clr, tmr_ld1, tmr_inc;
  logic             ack_ok;

  logic [CNT_W-1:0] cnt_val;
  logic             cnt_sat;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_sat;

  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] cnt_evt;
  logic             thr_hit;
  logic             tmo_hit;
  logic             sat_hit;

  // --------------------------------------------------------------------------
  // Live event counter and batch timer
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .load1_i (cnt_ld1),
    .inc_i   (cnt_inc),
    .cnt_o   (cnt_val),
    .sat_o   (cnt_sat)
  );

  sat_counter #(.W(TMR_W)) u_tmr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (tmr_clr),
    .load1_i (tmr_ld1),
    .inc_i   (tmr_inc),
    .cnt_o   (tmr_val),
    .sat_o   (tmr_sat)
  );

  // --------------------------------------------------------------------------
  // Trigger conditions (threshold and timeout are used live)
  // --------------------------------------------------------------------------
  assign thr_eff = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

  // Count including this cycle's event, held at all-ones.
  assign cnt_evt = (event_i && !cnt_sat) ? (cnt_val + CNT_W'(1)) : cnt_val;
  assign thr_hit = (cnt_evt >= thr_eff);

  // A saturated timer is at or above any programmable timeout.
  assign tmo_hit = (timeout_i != '0) && (tmr_sat || (tmr_val >= timeout_i));

  // Saturation "occurs" only when an event is counted into the top value;
  // a counter that merely sits at all-ones does not re-arm the sticky flag.
  assign sat_hit = enable_i && event_i && (cnt_evt == CNT_MAX);

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    cnt_clr = 1'b0;
    cnt_ld1 = 1'b0;
    cnt_inc = 1'b0;
    tmr_clr = 1'b0;
    tmr_ld1 = 1'b0;
    tmr_inc = 1'b0;
    ack_ok  = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
      batch_d = '0;
      cnt_clr = 1'b1;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (event_i) begin
            // Live count is zero here, so thr_hit means threshold of one.
            if (thr_hit) begin
              state_d = ST_IRQ;
              batch_d = cnt_evt;
              cnt_clr = 1'b1;
              tmr_clr = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_ld1 = 1'b1;
              tmr_ld1 = 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (thr_hit || tmo_hit) begin
            state_d = ST_IRQ;
            batch_d = cnt_evt;
            cnt_clr = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            cnt_inc = event_i;
            tmr_inc = 1'b1;
          end
        end

        ST_IRQ: begin
          if (ack_i) begin
            ack_ok = 1'b1;
            // Always leave IRQ for at least one cycle; a carried-over batch
            // that already meets the threshold re-fires from WAIT.
            if (cnt_evt == '0) begin
              state_d = ST_IDLE;
              cnt_clr = 1'b1;
              tmr_clr = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_inc = event_i;
              tmr_ld1 = 1'b1;
            end
          end else begin
            cnt_inc = event_i;
            tmr_clr = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  assign irq_d = (state_d == ST_IRQ);

  always_comb begin
    sat_d = sat_q;
    if (!enable_i) begin
      sat_d = 1'b0;
    end else if (sat_hit) begin
      sat_d = 1'b1;
    end else if (ack_ok) begin
      sat_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      batch_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      batch_q <= batch_d;
      sat_q   <= sat_d;
    end
  end

  assign irq_o       = irq_q;
  assign batch_cnt_o = batch_q;
  assign sat_o       = sat_q;

endmodule : irq_coalescer
`default_nettype wire

// File: tb/tb_irq_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_coalescer
// Purpose  : Self-checking bench for irq_coalescer: directed scenarios plus
//            randomized traffic compared cycle by cycle against a
//            behavioural model of the coalescing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_coalescer;

  localparam int CNT_W = 8;
  localparam int TMR_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int TMAX  = (1 << TMR_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             ev;
  logic [CNT_W-1:0] thresh;
  logic [TMR_W-1:0] timeout;
  logic             ack;
  logic             irq;
  logic [CNT_W-1:0] batch;
  logic             sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase 0 = no batch, 1 = collecting, 2 = interrupt.
  int m_phase;
  int m_cnt;
  int m_tmr;
  int m_batch;
  bit m_sat;

  irq_coalescer #(.CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .event_i     (ev),
    .thresh_i    (thresh),
    .timeout_i   (timeout),
    .ack_i       (ack),
    .irq_o       (irq),
    .batch_cnt_o (batch),
    .sat_o       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_tmr   = 0;
    m_batch = 0;
    m_sat   = 1'b0;
  endtask

  task automatic fire(input int n);
    m_phase = 2;
    m_batch = n;
    m_cnt   = 0;
    m_tmr   = 0;
  endtask

  // One clock edge worth of coalescing rules, from the inputs at the edge.
  task automatic model_step();
    int thr, total;
    bit accepted;
    if (!rst_n || !enable) begin
      model_reset();
      return;
    end
    thr      = (thresh == 0) ? 1 : int'(thresh);
    total    = m_cnt + (ev ? 1 : 0);
    if (total > CMAX) total = CMAX;
    accepted = 1'b0;
    case (m_phase)
      0: begin
        if (ev) begin
          if (thr <= 1) fire(1);
          else begin
            m_phase = 1;
            m_cnt   = 1;
            m_tmr   = 1;
          end
        end
      end
      1: begin
        if (total >= thr || (timeout != 0 && m_tmr >= int'(timeout))) fire(total);
        else begin
          m_cnt = total;
          m_tmr = (m_tmr + 1 > TMAX) ? TMAX : m_tmr + 1;
        end
      end
      default: begin
        if (ack) begin
          accepted = 1'b1;
          if (total == 0) m_phase = 0;
          else begin
            m_phase = 1;
            m_cnt   = total;
            m_tmr   = 1;
          end
        end else begin
          m_cnt = total;
        end
      end
    endcase
    if (ev && total == CMAX) m_sat = 1'b1;
    else if (accepted) m_sat = 1'b0;
  endtask

  task automatic check_model();
    check("irq_model",   32'(irq),   32'(m_phase == 2));
    check("batch_model", 32'(batch), 32'(m_batch));
    check("sat_model",   32'(sat),   32'(m_sat));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Called just after an active edge; reset asserts between edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_irq",   32'(irq),   32'd0);
    check("rst_batch", 32'(batch), 32'd0);
    check("rst_sat",   32'(sat),   32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    ev      = 1'b0;
    thresh  = '0;
    timeout = '0;
    ack     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq",   32'(irq),   32'd0);
    check("reset_batch", 32'(batch), 32'd0);
    check("reset_sat",   32'(sat),   32'd0);
    rst_n = 1'b1;
    tick();

    // Threshold 4, events at cycles 0,3,5,9 -> irq from cycle 10.
    thresh = 8'd4; timeout = '0;
    for (int c = 0; c <= 9; c++) begin
      ev = (c == 0 || c == 3 || c == 5 || c == 9);
      tick();
      if (c == 8) check("thr4_early", 32'(irq), 32'd0);
      if (c == 9) begin
        check("thr4_irq",   32'(irq),   32'd1);
        check("thr4_batch", 32'(batch), 32'd4);
      end
    end
    ev = 1'b0; ack = 1'b1; tick(); ack = 1'b0; tick();
    check("thr4_acked", 32'(irq), 32'd0);

    // Timeout 8 with unreachable threshold -> irq from cycle 9.
    thresh = 8'd100; timeout = 6'd8;
    for (int c = 0; c <= 8; c++) begin
      ev = (c == 0);
      tick();
      if (c == 7) check("tmo_early", 32'(irq), 32'd0);
      if (c == 8) begin
        check("tmo_irq",   32'(irq),   32'd1);
        check("tmo_batch", 32'(batch), 32'd1);
      end
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();

    // Carry-over: ack with an event in the same cycle still drops irq.
    thresh = 8'd2; timeout = '0;
    ev = 1'b1; repeat (2) tick();
    check("carry_first", 32'(batch), 32'd2);
    repeat (3) tick();
    ack = 1'b1; tick();
    check("carry_gap", 32'(irq), 32'd0);
    ev = 1'b0; ack = 1'b0; tick();
    check("carry_refire", 32'(irq),   32'd1);
    check("carry_batch",  32'(batch), 32'd4);
    ack = 1'b1; tick(); ack = 1'b0; tick();

    // Saturation of the live counter while in IRQ.
    thresh = 8'hFF; timeout = 6'd2;
    ev = 1'b1; tick(); ev = 1'b0; repeat (2) tick();
    check("sat_enter", 32'(irq), 32'd1);
    ev = 1'b1; repeat (CMAX + 5) tick();
    check("sat_set", 32'(sat), 32'd1);
    ev = 1'b0; ack = 1'b1; tick();
    check("sat_clr", 32'(sat), 32'd0);
    check("sat_gap", 32'(irq), 32'd0);
    ack = 1'b0; tick();
    check("sat_refire", 32'(batch), 32'(CMAX));
    ack = 1'b1; tick(); ack = 1'b0; tick();

    // Reset mid-batch discards the partial count.
    thresh = 8'd4; timeout = '0;
    ev = 1'b1; repeat (3) tick();
    ev = 1'b0;
    pulse_reset();
    ev = 1'b1; repeat (3) tick();
    check("rst_fresh_early", 32'(irq), 32'd0);
    tick();
    check("rst_fresh_irq",   32'(irq),   32'd1);
    check("rst_fresh_batch", 32'(batch), 32'd4);
    ev = 1'b0; ack = 1'b1; tick(); ack = 1'b0; tick();

    // Enable low during IRQ; later ack is ignored.
    thresh = 8'd1;
    ev = 1'b1; tick(); ev = 1'b0;
    check("en_irq", 32'(irq), 32'd1);
    enable = 1'b0; tick(); enable = 1'b1;
    check("en_drop",  32'(irq),   32'd0);
    check("en_batch", 32'(batch), 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_quiet", 32'(irq), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0)
        thresh = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(200, 255))
                                             : CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0)
        timeout = ($urandom_range(0, 3) == 0) ? '0 : TMR_W'($urandom_range(1, 12));
      ev     = ($urandom_range(0, 99) < 45);
      ack    = ($urandom_range(0, 99) < 20);
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_irq_coalescer
`default_nettype wire

// File: doc/irq_coalescer.md
IRQ_COALESCER -- requirements
Module: irq_coalescer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of event counters.
REQ-002 SHALL have parameter TMR_W, default 16: width of timeout timer.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_i  input  1  coalescer enable; low = synchronous clear.
REQ-006 SHALL have port event_i  input  1  single-cycle event pulse from upstream edge detector; each high cycle = one event.
REQ-007 SHALL have port thresh_i  input  CNT_W  events per interrupt; 0 treated as 1.
REQ-008 SHALL have port timeout_i  input  TMR_W  cycles from first batch event to forced IRQ; 0 = timer disabled.
REQ-009 SHALL have port ack_i  input  1  interrupt acknowledge pulse.
REQ-010 SHALL have port irq_o  output  1  level interrupt request, registered.
REQ-011 SHALL have port batch_cnt_o  output  CNT_W  event count of the batch that raised irq_o.
REQ-012 SHALL have port sat_o  output  1  sticky flag: live counter saturated since last ack.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, IRQ; internal live counter cnt, timer tmr.
REQ-014 Thr_eff = max(thresh_i,1); thresh_i and timeout_i SHALL be used live (no sampling); compare uses >=.
REQ-015 IDLE, event_i=1: cnt<=1, tmr<=1; if thr_eff==1 -> IRQ, else -> WAIT.
REQ-016 WAIT, each edge: cnt<=cnt+event_i (saturating); tmr<=tmr+1 (saturating).
REQ-017 WAIT -> IRQ when cnt+event_i >= thr_eff, or when timeout_i!=0 and tmr >= timeout_i; threshold check takes priority only for batch_cnt_o value, both yield IRQ.
REQ-018 On every entry to IRQ: batch_cnt_o <= count including the triggering-cycle event; cnt <= 0; tmr <= 0.
REQ-019 irq_o SHALL be high exactly while state is IRQ; rises the edge the transition is taken (visible next cycle).
REQ-020 IRQ: events SHALL keep incrementing cnt (carry-over batch); tmr held at 0.
REQ-021 IRQ with ack_i=1: if cnt+event_i==0 -> IDLE; else -> WAIT with cnt<=cnt+event_i, tmr<=1.
REQ-022 irq_o SHALL be low for at least one cycle after ack, even if carry-over count already >= thr_eff.
REQ-023 ack_i outside IRQ SHALL be ignored.
REQ-024 cnt SHALL saturate at 2^CNT_W-1; reaching saturation sets sat_o; sat_o clears on accepted ack (REQ-021) unless saturation occurs that same cycle.
REQ-025 tmr SHALL saturate at 2^TMR_W-1; no wrap.
REQ-026 enable_i=0: next edge state<=IDLE, cnt, tmr, batch_cnt_o, sat_o <= 0, irq_o <= 0; events ignored while low.
REQ-027 timeout_i lowered mid-batch below tmr SHALL trigger IRQ on next edge.

Reset
REQ-028 rst_n_i low SHALL asynchronously force IDLE, irq_o=0, batch_cnt_o=0, sat_o=0, cnt=0, tmr=0.
REQ-029 Reset release mid-batch: no event or partial count SHALL survive; first post-reset event starts a fresh batch.

Structure
REQ-030 FSM state enum typedef SHALL live in shared package netdma_irq_pkg.
REQ-031 SHALL instantiate sub-module sat_counter (parameterised width, inc, clear, load-1, sat flag) twice: cnt and tmr.
REQ-032 No combinational path from any input to irq_o.

Verification
REQ-033 thresh=4, timeout=0; events at cycles 0,3,5,9 -> irq_o high from cycle 10, batch_cnt_o=4.
REQ-034 thresh=100, timeout=8; single event at cycle 0 -> irq_o high from cycle 9, batch_cnt_o=1.
REQ-035 thresh=2; 3 events in IRQ, ack with 4th event same cycle -> irq_o low >=1 cycle, then high, batch_cnt_o=4.
REQ-036 CNT_W=4, thresh=0xF... hold event_i high 20 cycles in IRQ -> cnt saturates 15, sat_o=1; ack -> sat_o=0.
REQ-037 rst_n_i pulsed low mid-WAIT (cnt=3) -> immediate irq_o=0, batch_cnt_o=0; thresh=4 then requires 4 new events.
REQ-038 enable_i low 1 cycle during IRQ -> irq_o low next cycle, ack afterwards ignored, no spurious IRQ.
